// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads the combinational instruction memory and
// registers {pc, instruction, pc+4} into a valid/ready output slot for decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_LIMIT    = 64,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC_out,
  input  logic [31:0] instruction_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] PC_LIMIT_W = 32'(PC_LIMIT);
  localparam logic [3:0]  START_CNT  = 4'(START_DELAY);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instruction_q, if_instruction_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic        fire;
  logic        in_range;
  logic [31:0] pc_next;

  assign fire     = !if_valid_q || if_ready;
  assign in_range = (pc_q < PC_LIMIT_W) && (pc_q[1:0] == 2'b00);
  assign pc_next  = pc_q + 32'd4;

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    pc_d             = pc_q;
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    if_instruction_d = if_instruction_q;
    if_pc_plus4_d    = if_pc_plus4_q;
    fault_d          = fault_q;
    fault_pc_d       = fault_pc_q;

    unique case (state_q)
      S_WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) state_d = S_RUN;
      end
      S_RUN: begin
        // Redirect wins over capture; a held instruction is only replaced once
        // decode has taken it (fire), so nothing is ever dropped.
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
        end else if (fire && in_range) begin
          if_instruction_d = instruction_in;
          if_pc_d          = pc_q;
          if_pc_plus4_d    = pc_next;
          if_valid_d       = 1'b1;
          pc_d             = pc_next;
        end else if (fire) begin
          if_valid_d = 1'b0;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          state_d    = S_FAULT;
        end
      end
      S_FAULT: begin
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          fault_d = 1'b0;
          pc_d    = redirect_pc;
          state_d = S_RUN;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= (START_DELAY == 0) ? S_RUN : S_WAIT;
      wait_cnt_q       <= START_CNT;
      pc_q             <= RESET_PC;
      if_valid_q       <= 1'b0;
      if_pc_q          <= '0;
      if_instruction_q <= '0;
      if_pc_plus4_q    <= '0;
      fault_q          <= 1'b0;
      fault_pc_q       <= '0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      pc_q             <= pc_d;
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      if_instruction_q <= if_instruction_d;
      if_pc_plus4_q    <= if_pc_plus4_d;
      fault_q          <= fault_d;
      fault_pc_q       <= fault_pc_d;
    end
  end

  assign PC_out         = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instruction_q;
  assign if_pc_plus4    = if_pc_plus4_q;
  assign fault          = fault_q;
  assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch;

  localparam int unsigned LIMIT = 64;
  localparam int unsigned DELAY = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_out;
  logic [31:0] instruction_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  logic [31:0] m_pc, m_opc, m_oins, m_op4, m_fpc;
  logic        m_ov, m_faulted;
  int          m_delay;

  always #5 clk = ~clk;

  assign instruction_in = mem[PC_out[5:2]];

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .PC_LIMIT   (LIMIT),
    .START_DELAY(DELAY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_out        (PC_out),
    .instruction_in(instruction_in),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_ready      (if_ready),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instruction(if_instruction),
    .if_pc_plus4   (if_pc_plus4),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the reference behaviour, using the inputs seen at the edge.
  task automatic model_step();
    if (rst) begin
      m_pc = 32'h0; m_ov = 1'b0; m_opc = '0; m_oins = '0; m_op4 = '0;
      m_faulted = 1'b0; m_fpc = '0; m_delay = DELAY;
    end else if (m_faulted) begin
      m_ov = 1'b0;
      if (redirect_valid) begin
        m_faulted = 1'b0;
        m_pc = redirect_pc;
      end
    end else if (m_delay > 0) begin
      if (redirect_valid) m_pc = redirect_pc;
      m_delay--;
    end else if (redirect_valid) begin
      m_pc = redirect_pc;
      m_ov = 1'b0;
    end else if (!m_ov || if_ready) begin
      if (m_pc < LIMIT && m_pc % 4 == 0) begin
        m_ov   = 1'b1;
        m_opc  = m_pc;
        m_oins = mem[(m_pc / 4) % 16];
        m_op4  = m_pc + 4;
        m_pc   = m_pc + 4;
      end else begin
        m_ov = 1'b0;
        m_faulted = 1'b1;
        m_fpc = m_pc;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("PC_out", PC_out, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_ov));
    chk("if_pc", if_pc, m_opc);
    chk("if_instruction", if_instruction, m_oins);
    chk("if_pc_plus4", if_pc_plus4, m_op4);
    chk("fault", 32'(fault), 32'(m_faulted));
    chk("fault_pc", fault_pc, m_fpc);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[1] = 32'h019806B3;
    mem[2] = 32'h403402B3;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    m_pc = '0; m_ov = 1'b0; m_opc = '0; m_oins = '0; m_op4 = '0;
    m_faulted = 1'b0; m_fpc = '0; m_delay = DELAY;

    cycle();
    chk("reset_if_valid", 32'(if_valid), 32'd0);
    chk("reset_PC_out", PC_out, 32'd0);
    rst = 1'b0;
    cycle();
    chk("wait_no_valid", 32'(if_valid), 32'd0);
    cycle();
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_pc", if_pc, 32'd0);
    cycle();
    chk("second_pc", if_pc, 32'd4);
    chk("second_ins", if_instruction, 32'h019806B3);
    cycle();
    chk("third_pc", if_pc, 32'd8);
    chk("third_ins", if_instruction, 32'h403402B3);
    chk("third_p4", if_pc_plus4, 32'd12);

    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_if_pc", if_pc, 32'd8);
      chk("bp_ins", if_instruction, 32'h403402B3);
      chk("bp_valid", 32'(if_valid), 32'd1);
      chk("bp_PC_out", PC_out, 32'd12);
    end
    if_ready = 1'b1;
    cycle();
    chk("bp_release_pc", if_pc, 32'd12);
    cycle();
    chk("pre_redirect_pc", if_pc, 32'd16);

    redirect_valid = 1'b1; redirect_pc = 32'h2C;
    cycle();
    redirect_valid = 1'b0;
    chk("redir_bubble", 32'(if_valid), 32'd0);
    chk("redir_PC_out", PC_out, 32'h2C);
    cycle();
    chk("redir_pc", if_pc, 32'h2C);
    chk("redir_p4", if_pc_plus4, 32'h30);

    for (int i = 0; i < 20 && !fault; i++) cycle();
    chk("limit_fault", 32'(fault), 32'd1);
    chk("limit_fault_pc", fault_pc, 32'd64);
    chk("limit_valid", 32'(if_valid), 32'd0);
    cycle();
    chk("limit_PC_hold", PC_out, 32'd64);

    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cycle();
    redirect_valid = 1'b0;
    chk("fault_clear", 32'(fault), 32'd0);
    cycle();
    chk("recover_valid", 32'(if_valid), 32'd1);
    chk("recover_pc", if_pc, 32'd0);

    redirect_valid = 1'b1; redirect_pc = 32'h6;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("misalign_fault", 32'(fault), 32'd1);
    chk("misalign_fpc", fault_pc, 32'd6);
    chk("misalign_valid", 32'(if_valid), 32'd0);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_PC_out", PC_out, 32'd0);
    cycle();
    chk("rst_wait", 32'(if_valid), 32'd0);
    cycle();
    chk("rst_first", 32'(if_valid), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 9))
        7: redirect_pc = 32'($urandom_range(0, 63));
        8: redirect_pc = 32'h100 + 32'($urandom_range(0, 15) * 4);
        9: redirect_pc = 32'd60;
        default: redirect_pc = 32'($urandom_range(0, 15) * 4);
      endcase
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
